zxuno_busfabric: RTL and testbench
==================================

Name: zxuno_busfabric

Overview:
- Parametrised successor to the hand-written CPU data-in priority chain and ZX-Uno register-port glue in the Spectrum core top level.
- Decodes the ZX-Uno address/data I/O ports and generates single-cycle register strobes.
- Merges NSRC peripheral read sources into one registered CPU data bus using a fixed priority.
- Detects and counts bus collisions; exposes the counter as a ZX-Uno register.

Parameters:
- NSRC, 16, number of peripheral read sources; 1..32.
- ADDR_PORT, 16'hFC3B, ZX-Uno register address port.
- DATA_PORT, 16'hFD3B, ZX-Uno register data port.
- COLL_REG, 8'hFE, ZX-Uno register number of the collision counter.

Ports:
- clk  in  1  system clock, 28 MHz; CPU strobes are sampled in this domain.
- rst_n  in  1  synchronous reset, active low.
- a  in  16  CPU address.
- iorq_n, rd_n, wr_n, m1_n  in  1 each  Z80 control.
- din  in  8  CPU data out.
- src_data  in  8*NSRC  source read data; source i occupies bits [8i+7:8i].
- src_oe_n  in  NSRC  source output enables, active low.
- dflt_data  in  8  fallback data (ULA).
- dout  out  8  registered data to the CPU data-in.
- addr  out  8  current ZX-Uno register address.
- read_from_reg  out  1  level; data-port read in progress.
- write_to_reg  out  1  one-cycle data-port write strobe.
- regaddr_changed  out  1  one-cycle pulse on an address-port write.
- collision  out  1  sticky collision flag.

Behaviour:
- Reset: with rst_n low at a clk edge, all of the following are cleared on that edge:
  - addr = 8'h00, dout = 8'hFF;
  - strobes = 0, collision = 0, counter = 0;
  - edge-detect history cleared.
- I/O cycle qualification: io_rd = !iorq_n & m1_n & !rd_n; io_wr = !iorq_n & m1_n & !wr_n. Interrupt acknowledge (m1_n low) is ignored.
- io_rd and io_wr are registered once (rd_q, wr_q) for rising-edge detection.
- Address-port write:
  - First clk where io_wr & a==ADDR_PORT & !wr_q: addr <= din.
  - regaddr_changed = 1 for exactly the following cycle.
  - A held write gives no further pulses.
- Data-port write:
  - First clk where io_wr & a==DATA_PORT & !wr_q: write_to_reg pulses 1 cycle later.
  - If addr==COLL_REG: the counter and collision clear at that same edge.
- Data-port read: read_from_reg = registered (io_rd & a==DATA_PORT); 1-cycle latency, held while the read persists.
- Read mux, registered, evaluated every clk, latency 1. Priority:
  1. Internal address-port read (io_rd & a==ADDR_PORT) returns addr.
  2. Internal COLL_REG read (io_rd & a==DATA_PORT & addr==COLL_REG) returns the counter.
  3. Lowest-index i with src_oe_n[i]==0 returns src_data[i].
  4. Otherwise dflt_data.
- Collision detection:
  - On any clk where two or more enables are active (external src_oe_n bits plus internal enables 1 and 2 above), the counter increments, saturating at 255, and collision <= 1.
  - Same-cycle clear and collision: clear wins; the counter becomes 0.
- Simultaneous address-port and data-port write cannot occur (distinct a). An address write in the cycle after a data write is legal; strobes are independent.
- rst_n asserted mid-cycle: any pending strobe is suppressed. After release, an I/O cycle still asserted is treated as new (history is 0) and produces one strobe.

Decomposition:
- Package zxuno_bus_pkg: port constants, COLL_REG default, and a popcount-ge-2 function.
- One sub-module, zxuno_prio_mux: parametrised priority encoder plus data select over NSRC, reused by the core's future video-layer mixer.

Test Plan:
- Reset then idle, all src_oe_n high, dflt_data=8'h5A -> dout=8'hFF during reset, 8'h5A one clk after release; no strobes.
- OUT (FC3B),8'h0F with io_wr held 4 clks -> addr=8'h0F, regaddr_changed high exactly 1 cycle; a following IN (FC3B) -> dout=8'h0F.
- addr=8'h0F, OUT (FD3B),8'hA5 held 3 clks -> write_to_reg one pulse; IN (FD3B) -> read_from_reg high from cycle+1 until release.
- src_oe_n[3] and [7] low, data 8'h33/8'h77 -> dout=8'h33, collision=1, counter=1 after one clk; held 300 clks -> counter saturates at 255.
- addr=8'hFE, IN (FD3B) -> dout=counter; OUT (FD3B) while a collision persists -> counter=0 and collision=0 (clear wins).
- rst_n low for 1 clk during a held address-port write -> addr=8'h00; after release, exactly one regaddr_changed pulse and addr=din.

Source files
------------

// File: rtl/zxuno_bus_pkg.sv
// Shared constants and helpers for the ZX-Uno CPU bus fabric.
package zxuno_bus_pkg;

    localparam int          MAX_SRC           = 32;
    localparam int          EN_W              = MAX_SRC + 2;
    localparam logic [15:0] ZXUNO_ADDR_PORT   = 16'hFC3B;
    localparam logic [15:0] ZXUNO_DATA_PORT   = 16'hFD3B;
    localparam logic [7:0]  ZXUNO_COLL_REG    = 8'hFE;

    // True when at least two bits of the enable vector are set.
    function automatic logic popcount_ge2(input logic [EN_W-1:0] v);
        logic seen_one;
        logic seen_two;
        seen_one = 1'b0;
        seen_two = 1'b0;
        for (int i = 0; i < EN_W; i++) begin
            if (v[i]) begin
                if (seen_one) seen_two = 1'b1;
                seen_one = 1'b1;
            end
        end
        return seen_two;
    endfunction

endpackage

// File: rtl/zxuno_prio_mux.sv
// Fixed-priority data select: lowest-index source with an active-low
// enable wins; the fallback value is used when no source is enabled.
module zxuno_prio_mux #(
    parameter int NSRC = 16,
    parameter int W    = 8
) (
    input  logic [W*NSRC-1:0] i_data,
    input  logic [NSRC-1:0]   i_oe_n,
    input  logic [W-1:0]      i_dflt,
    output logic [W-1:0]      o_data
);

    // Scan from the top down so the lowest enabled index is the last to assign.
    always_comb begin
        o_data = i_dflt;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (!i_oe_n[i]) o_data = i_data[i*W +: W];
        end
    end

endmodule

// File: rtl/zxuno_busfabric.sv
// CPU data-in merge and ZX-Uno register-port decode with collision counting.
module zxuno_busfabric
    import zxuno_bus_pkg::*;
#(
    parameter int          NSRC      = 16,
    parameter logic [15:0] ADDR_PORT = ZXUNO_ADDR_PORT,
    parameter logic [15:0] DATA_PORT = ZXUNO_DATA_PORT,
    parameter logic [7:0]  COLL_REG  = ZXUNO_COLL_REG
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         a,
    input  logic                iorq_n,
    input  logic                rd_n,
    input  logic                wr_n,
    input  logic                m1_n,
    input  logic [7:0]          din,
    input  logic [8*NSRC-1:0]   src_data,
    input  logic [NSRC-1:0]     src_oe_n,
    input  logic [7:0]          dflt_data,
    output logic [7:0]          dout,
    output logic [7:0]          addr,
    output logic                read_from_reg,
    output logic                write_to_reg,
    output logic                regaddr_changed,
    output logic                collision
);

    logic            r_rd_q;
    logic            r_wr_q;
    logic [7:0]      r_addr;
    logic [7:0]      r_dout;
    logic [7:0]      r_cnt;
    logic            r_coll;
    logic            r_rfr;
    logic            r_wtr;
    logic            r_rac;

    logic            w_io_rd;
    logic            w_io_wr;
    logic            w_addr_wr;
    logic            w_data_wr;
    logic            w_int_addr;
    logic            w_int_coll;
    logic            w_clear;
    logic            w_multi_en;
    logic [EN_W-1:0] w_en_vec;
    logic [7:0]      w_src_sel;
    logic [7:0]      w_dout_nxt;

    // Interrupt acknowledge (m1_n low) never counts as an I/O cycle.
    assign w_io_rd    = !iorq_n && m1_n && !rd_n;
    assign w_io_wr    = !iorq_n && m1_n && !wr_n;
    assign w_addr_wr  = w_io_wr && (a == ADDR_PORT) && !r_wr_q;
    assign w_data_wr  = w_io_wr && (a == DATA_PORT) && !r_wr_q;
    assign w_int_addr = w_io_rd && (a == ADDR_PORT);
    assign w_int_coll = w_io_rd && (a == DATA_PORT) && (r_addr == COLL_REG);
    assign w_clear    = w_data_wr && (r_addr == COLL_REG);

    zxuno_prio_mux #(
        .NSRC (NSRC),
        .W    (8)
    ) u_prio_mux (
        .i_data (src_data),
        .i_oe_n (src_oe_n),
        .i_dflt (dflt_data),
        .o_data (w_src_sel)
    );

    // Gather every driver enable, internal ones included, for collision detection.
    always_comb begin
        w_en_vec                 = '0;
        w_en_vec[NSRC-1:0]       = ~src_oe_n;
        w_en_vec[MAX_SRC]        = w_int_addr;
        w_en_vec[MAX_SRC + 1]    = w_int_coll;
    end

    assign w_multi_en = popcount_ge2(w_en_vec);

    // Internal registers take precedence over the external sources.
    always_comb begin
        w_dout_nxt = w_src_sel;
        if (w_int_addr)      w_dout_nxt = r_addr;
        else if (w_int_coll) w_dout_nxt = r_cnt;
    end

    // Edge history, register address, strobes and registered read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_q <= 1'b0;
            r_wr_q <= 1'b0;
            r_addr <= 8'h00;
            r_dout <= 8'hFF;
            r_rfr  <= 1'b0;
            r_wtr  <= 1'b0;
            r_rac  <= 1'b0;
        end else begin
            r_rd_q <= w_io_rd;
            r_wr_q <= w_io_wr;
            r_dout <= w_dout_nxt;
            r_rfr  <= w_io_rd && (a == DATA_PORT);
            r_wtr  <= w_data_wr;
            r_rac  <= w_addr_wr;
            if (w_addr_wr) r_addr <= din;
        end
    end

    // Saturating collision counter; a write to the counter register clears it
    // even if a collision happens on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= 8'h00;
            r_coll <= 1'b0;
        end else if (w_clear) begin
            r_cnt  <= 8'h00;
            r_coll <= 1'b0;
        end else if (w_multi_en) begin
            r_coll <= 1'b1;
            if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
        end
    end

    assign dout            = r_dout;
    assign addr            = r_addr;
    assign read_from_reg   = r_rfr;
    assign write_to_reg    = r_wtr;
    assign regaddr_changed = r_rac;
    assign collision       = r_coll;

endmodule

// File: tb/tb_zxuno_busfabric.sv
// Bench for zxuno_busfabric: directed scenarios plus random bus traffic,
// checked every cycle against a behavioural model.
module tb_zxuno_busfabric;

    localparam int NSRC = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0]       a;
    logic              iorq_n, rd_n, wr_n, m1_n;
    logic [7:0]        din;
    logic [8*NSRC-1:0] src_data;
    logic [NSRC-1:0]   src_oe_n;
    logic [7:0]        dflt_data;
    logic [7:0]        dout, addr;
    logic              read_from_reg, write_to_reg, regaddr_changed, collision;

    int n_checks = 0;
    int n_fail   = 0;

    zxuno_busfabric #(.NSRC(NSRC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .a               (a),
        .iorq_n          (iorq_n),
        .rd_n            (rd_n),
        .wr_n            (wr_n),
        .m1_n            (m1_n),
        .din             (din),
        .src_data        (src_data),
        .src_oe_n        (src_oe_n),
        .dflt_data       (dflt_data),
        .dout            (dout),
        .addr            (addr),
        .read_from_reg   (read_from_reg),
        .write_to_reg    (write_to_reg),
        .regaddr_changed (regaddr_changed),
        .collision       (collision)
    );

    always #5 clk = ~clk;

    // Behavioural model state: what the CPU-visible registers must hold.
    logic [7:0] m_addr, m_dout;
    int         m_cnt;
    logic       m_coll, m_rac, m_wtr, m_rfr;
    logic       m_prev_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit   rd_cyc, wr_cyc, rd_addr_reg, rd_cnt_reg, addr_write, data_write;
        int   drivers, first;
        logic [7:0] nxt;
        if (!rst_n) begin
            m_addr = 8'h00; m_dout = 8'hFF; m_cnt = 0; m_coll = 0;
            m_rac = 0; m_wtr = 0; m_rfr = 0; m_prev_wr = 0;
            return;
        end
        rd_cyc      = !iorq_n && m1_n && !rd_n;
        wr_cyc      = !iorq_n && m1_n && !wr_n;
        rd_addr_reg = rd_cyc && a == 16'hFC3B;
        rd_cnt_reg  = rd_cyc && a == 16'hFD3B && m_addr == 8'hFE;
        drivers = int'(rd_addr_reg) + int'(rd_cnt_reg);
        first = -1;
        for (int i = 0; i < NSRC; i++) begin
            if (src_oe_n[i] == 1'b0) begin
                drivers++;
                if (first < 0) first = i;
            end
        end
        if (rd_addr_reg)     nxt = m_addr;
        else if (rd_cnt_reg) nxt = m_cnt[7:0];
        else if (first >= 0) nxt = src_data[8*first +: 8];
        else                 nxt = dflt_data;
        addr_write = wr_cyc && a == 16'hFC3B && !m_prev_wr;
        data_write = wr_cyc && a == 16'hFD3B && !m_prev_wr;
        if (data_write && m_addr == 8'hFE) begin
            m_cnt = 0; m_coll = 0;
        end else if (drivers >= 2) begin
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_coll = 1;
        end
        m_dout    = nxt;
        m_rac     = addr_write;
        m_wtr     = data_write;
        m_rfr     = rd_cyc && a == 16'hFD3B;
        m_prev_wr = wr_cyc;
        if (addr_write) m_addr = din;
    endtask

    // Advance the model on every edge and compare shortly after.
    always @(posedge clk) begin
        model_step();
        #1;
        chk("dout",            {24'h0, dout},            {24'h0, m_dout});
        chk("addr",            {24'h0, addr},            {24'h0, m_addr});
        chk("read_from_reg",   {31'h0, read_from_reg},   {31'h0, m_rfr});
        chk("write_to_reg",    {31'h0, write_to_reg},    {31'h0, m_wtr});
        chk("regaddr_changed", {31'h0, regaddr_changed}, {31'h0, m_rac});
        chk("collision",       {31'h0, collision},       {31'h0, m_coll});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_idle();
        iorq_n = 1; rd_n = 1; wr_n = 1; m1_n = 1;
    endtask

    task automatic io_out(input logic [15:0] port, input logic [7:0] d);
        a = port; din = d; iorq_n = 0; wr_n = 0; rd_n = 1; m1_n = 1;
    endtask

    task automatic io_in(input logic [15:0] port);
        a = port; iorq_n = 0; rd_n = 0; wr_n = 1; m1_n = 1;
    endtask

    task automatic drive_random();
        int op;
        case ($urandom_range(0, 3))
            0:       a = 16'hFC3B;
            1:       a = 16'hFD3B;
            default: a = 16'($urandom);
        endcase
        iorq_n = ($urandom_range(0, 3) == 0);
        m1_n   = ($urandom_range(0, 9) != 0);
        op = $urandom_range(0, 2);
        rd_n = (op != 0);
        wr_n = (op != 1);
        din  = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
        for (int i = 0; i < NSRC; i++) begin
            src_data[8*i +: 8] = 8'($urandom);
            src_oe_n[i] = 1'b1;
        end
        if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < NSRC; i++) src_oe_n[i] = ($urandom_range(0, 5) != 0);
        end
        dflt_data = 8'($urandom);
        rst_n = ($urandom_range(0, 79) != 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; a = 16'h0000; din = 8'h00; bus_idle();
        src_data = '0; src_oe_n = '1; dflt_data = 8'h5A;
        tick(2);
        chk("lit_reset_dout", {24'h0, dout}, 32'hFF);
        chk("lit_reset_addr", {24'h0, addr}, 32'h00);
        rst_n = 1;
        tick(1);
        chk("lit_idle_dout", {24'h0, dout}, 32'h5A);
        chk("lit_idle_rac", {31'h0, regaddr_changed}, 32'h0);
        chk("lit_idle_wtr", {31'h0, write_to_reg}, 32'h0);

        // Address-port write held for 4 clocks.
        io_out(16'hFC3B, 8'h0F);
        tick(1);
        chk("lit_aw_pulse", {31'h0, regaddr_changed}, 32'h1);
        chk("lit_aw_addr", {24'h0, addr}, 32'h0F);
        tick(1);
        chk("lit_aw_single", {31'h0, regaddr_changed}, 32'h0);
        tick(2);
        bus_idle(); tick(1);
        io_in(16'hFC3B); tick(1);
        chk("lit_addr_readback", {24'h0, dout}, 32'h0F);
        bus_idle(); tick(1);

        // Data-port write held 3 clocks, then a data-port read.
        io_out(16'hFD3B, 8'hA5);
        tick(1);
        chk("lit_dw_pulse", {31'h0, write_to_reg}, 32'h1);
        tick(1);
        chk("lit_dw_single", {31'h0, write_to_reg}, 32'h0);
        tick(1);
        bus_idle(); tick(1);
        io_in(16'hFD3B); tick(1);
        chk("lit_rfr_rise", {31'h0, read_from_reg}, 32'h1);
        tick(2);
        chk("lit_rfr_hold", {31'h0, read_from_reg}, 32'h1);
        bus_idle(); tick(1);
        chk("lit_rfr_fall", {31'h0, read_from_reg}, 32'h0);

        // Point the register address at the collision counter.
        io_out(16'hFC3B, 8'hFE); tick(1);
        bus_idle(); tick(1);

        // Two sources at once: lowest index wins and a collision is counted.
        src_data[8*3 +: 8] = 8'h33; src_data[8*7 +: 8] = 8'h77;
        src_oe_n[3] = 0; src_oe_n[7] = 0;
        tick(1);
        chk("lit_prio_dout", {24'h0, dout}, 32'h33);
        chk("lit_coll_set", {31'h0, collision}, 32'h1);
        src_oe_n = '1;
        io_in(16'hFD3B); tick(1);
        chk("lit_cnt_one", {24'h0, dout}, 32'h01);
        bus_idle();
        src_oe_n[3] = 0; src_oe_n[7] = 0;
        tick(300);
        src_oe_n = '1;
        io_in(16'hFD3B); tick(1);
        chk("lit_cnt_sat", {24'h0, dout}, 32'hFF);
        bus_idle(); tick(1);

        // Clear the counter while a collision is still present: clear wins.
        src_oe_n[3] = 0; src_oe_n[7] = 0;
        io_out(16'hFD3B, 8'h00); tick(1);
        chk("lit_clear_coll", {31'h0, collision}, 32'h0);
        src_oe_n = '1;
        bus_idle(); tick(1);
        io_in(16'hFD3B); tick(1);
        chk("lit_cnt_cleared", {24'h0, dout}, 32'h00);
        bus_idle(); tick(1);

        // Reset in the middle of a held address-port write.
        io_out(16'hFC3B, 8'h3C); tick(1);
        chk("lit_pre_rst_addr", {24'h0, addr}, 32'h3C);
        tick(1);
        rst_n = 0; tick(1);
        chk("lit_rst_addr", {24'h0, addr}, 32'h00);
        chk("lit_rst_rac", {31'h0, regaddr_changed}, 32'h0);
        rst_n = 1; tick(1);
        chk("lit_post_rst_rac", {31'h0, regaddr_changed}, 32'h1);
        chk("lit_post_rst_addr", {24'h0, addr}, 32'h3C);
        tick(1);
        chk("lit_post_rst_single", {31'h0, regaddr_changed}, 32'h0);
        bus_idle(); tick(1);

        // Random traffic, each pattern held for a few clocks.
        for (int n = 0; n < 1200; n++) begin
            drive_random();
            tick($urandom_range(1, 4));
        end
        rst_n = 1; bus_idle(); src_oe_n = '1;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
